// File: rtl/jtag_tap_sync.sv
// JTAG TAP controller oversampled into the clk domain: tck/tms/tdi pass through synchronizers and the
// IEEE 1149.1 state machine advances on detected tck edges. Optional IDCODE register gated by JTAG_TAP_IDCODE_EN.
module jtag_tap_sync #(
    parameter int                IR_LEN       = 4,
    parameter int                USER_DR_LEN  = 32,
    parameter logic [31:0]       IDCODE_VALUE = 32'h149511C3,
    parameter logic [IR_LEN-1:0] USER_OP      = IR_LEN'(4'h8),
    parameter int                SYNC_STAGES  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tck,
    input  logic                   tms,
    input  logic                   tdi,
    output logic                   tdo,
    output logic                   tdo_oe,
    input  logic [USER_DR_LEN-1:0] user_capture_data,
    output logic [USER_DR_LEN-1:0] user_update_data,
    output logic                   user_capture,
    output logic                   user_update,
    output logic [3:0]             tap_state,
    output logic [IR_LEN-1:0]      ir
);

    typedef enum logic [3:0] {
        TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
        SH_DR  = 4'd4,  EX1_DR = 4'd5,  PAU_DR = 4'd6,  EX2_DR = 4'd7,
        UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
        EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
    } tap_state_t;

`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [IR_LEN-1:0] DEFAULT_IR = IR_LEN'(1);
`else
    localparam logic [IR_LEN-1:0] DEFAULT_IR = '1;
`endif

    logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync;
    logic                   tck_d;
    logic                   tck_s, tms_s, tdi_s, tck_rise, tck_fall;
    tap_state_t             state, state_nxt;
    logic [IR_LEN-1:0]      ir_sr;
    logic [USER_DR_LEN-1:0] user_sr;
    logic                   bypass_sr;
    logic                   sel_id, sel_user, id_lsb;

    always_ff @(posedge clk) begin
        if (rst) begin
            tck_sync <= '0;
            tms_sync <= '0;
            tdi_sync <= '0;
            tck_d    <= 1'b0;
        end else begin
            tck_sync[0] <= tck;
            tms_sync[0] <= tms;
            tdi_sync[0] <= tdi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                tck_sync[i] <= tck_sync[i-1];
                tms_sync[i] <= tms_sync[i-1];
                tdi_sync[i] <= tdi_sync[i-1];
            end
            tck_d <= tck_sync[SYNC_STAGES-1];
        end
    end

    assign tck_s    = tck_sync[SYNC_STAGES-1];
    assign tms_s    = tms_sync[SYNC_STAGES-1];
    assign tdi_s    = tdi_sync[SYNC_STAGES-1];
    assign tck_rise = tck_s & ~tck_d;
    assign tck_fall = ~tck_s & tck_d;

    always_ff @(posedge clk) begin
        if (rst) state <= TLR;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (tck_rise) begin
            case (state)
                TLR:    state_nxt = tms_s ? TLR    : RTI;
                RTI:    state_nxt = tms_s ? SEL_DR : RTI;
                SEL_DR: state_nxt = tms_s ? SEL_IR : CAP_DR;
                CAP_DR: state_nxt = tms_s ? EX1_DR : SH_DR;
                SH_DR:  state_nxt = tms_s ? EX1_DR : SH_DR;
                EX1_DR: state_nxt = tms_s ? UPD_DR : PAU_DR;
                PAU_DR: state_nxt = tms_s ? EX2_DR : PAU_DR;
                EX2_DR: state_nxt = tms_s ? UPD_DR : SH_DR;
                UPD_DR: state_nxt = tms_s ? SEL_DR : RTI;
                SEL_IR: state_nxt = tms_s ? TLR    : CAP_IR;
                CAP_IR: state_nxt = tms_s ? EX1_IR : SH_IR;
                SH_IR:  state_nxt = tms_s ? EX1_IR : SH_IR;
                EX1_IR: state_nxt = tms_s ? UPD_IR : PAU_IR;
                PAU_IR: state_nxt = tms_s ? EX2_IR : PAU_IR;
                EX2_IR: state_nxt = tms_s ? UPD_IR : SH_IR;
                UPD_IR: state_nxt = tms_s ? SEL_DR : RTI;
                default: state_nxt = TLR;
            endcase
        end
    end

    // IDCODE wins over USER_OP if both decode to the same code
    always_comb begin
        sel_id = 1'b0;
`ifdef JTAG_TAP_IDCODE_EN
        sel_id = (ir == IR_LEN'(1));
`endif
        sel_user = !sel_id && (ir == USER_OP);
    end

`ifdef JTAG_TAP_IDCODE_EN
    logic [31:0] id_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            id_sr <= '0;
        end else if (tck_rise && sel_id) begin
            if (state == CAP_DR)     id_sr <= IDCODE_VALUE;
            else if (state == SH_DR) id_sr <= {tdi_s, id_sr[31:1]};
        end
    end
    assign id_lsb = id_sr[0];
`else
    assign id_lsb = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_sr            <= '0;
            user_sr          <= '0;
            bypass_sr        <= 1'b0;
            ir               <= DEFAULT_IR;
            tdo              <= 1'b0;
            user_update_data <= '0;
            user_capture     <= 1'b0;
            user_update      <= 1'b0;
        end else begin
            user_capture <= 1'b0;
            user_update  <= 1'b0;
            if (tck_rise) begin
                case (state)
                    CAP_IR: ir_sr <= IR_LEN'(2'b01);
                    SH_IR:  ir_sr <= {tdi_s, ir_sr[IR_LEN-1:1]};
                    CAP_DR: begin
                        if (sel_user) begin
                            user_sr      <= user_capture_data;
                            user_capture <= 1'b1;
                        end else if (!sel_id) begin
                            bypass_sr <= 1'b0;
                        end
                    end
                    SH_DR: begin
                        if (sel_user)
                            user_sr <= (user_sr >> 1) | (USER_DR_LEN'(tdi_s) << (USER_DR_LEN-1));
                        else if (!sel_id)
                            bypass_sr <= tdi_s;
                    end
                    default: ;
                endcase
                if (state_nxt == TLR) ir <= DEFAULT_IR;
            end
            if (tck_fall) begin
                case (state)
                    SH_IR:  tdo <= ir_sr[0];
                    SH_DR:  tdo <= sel_id ? id_lsb : (sel_user ? user_sr[0] : bypass_sr);
                    UPD_IR: ir  <= ir_sr;
                    UPD_DR: begin
                        if (sel_user) begin
                            user_update_data <= user_sr;
                            user_update      <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign tdo_oe    = (state == SH_DR) || (state == SH_IR);
    assign tap_state = state;

endmodule

// File: tb/tb_jtag_tap_sync.sv
// Drives JTAG scans with randomized data and tms; a reference TAP model predicts a snapshot per tck
// cycle into a queue, and a monitor process pops and compares each snapshot against the DUT.
module tb_jtag_tap_sync;
    logic        clk = 1'b0;
    logic        rst, tck, tms, tdi;
    logic        tdo, tdo_oe, user_capture, user_update;
    logic [31:0] user_capture_data, user_update_data;
    logic [3:0]  tap_state, ir;

    always #5 clk = ~clk;

    jtag_tap_sync dut (
        .clk(clk), .rst(rst), .tck(tck), .tms(tms), .tdi(tdi),
        .tdo(tdo), .tdo_oe(tdo_oe),
        .user_capture_data(user_capture_data), .user_update_data(user_update_data),
        .user_capture(user_capture), .user_update(user_update),
        .tap_state(tap_state), .ir(ir)
    );

`ifdef JTAG_TAP_IDCODE_EN
    localparam bit ID_EN = 1'b1;
`else
    localparam bit ID_EN = 1'b0;
`endif
    localparam logic [3:0] DEF_IR = ID_EN ? 4'h1 : 4'hF;

    // IEEE 1149.1 transition table, indexed by state code
    int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

    typedef struct {
        logic [3:0]  st;
        logic        tdo;
        logic        oe;
        logic [3:0]  ir;
        logic [31:0] upd;
        int          nupd;
        int          ncap;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0;
    int n_upd_seen = 0, n_cap_seen = 0;

    int          m_st, m_nupd = 0, m_ncap = 0;
    logic        m_tdo, m_byp;
    logic [3:0]  m_ir, m_irsr;
    logic [31:0] m_id, m_usr, m_upd;

    always @(posedge clk) begin
        if (user_update)  n_upd_seen <= n_upd_seen + 1;
        if (user_capture) n_cap_seen <= n_cap_seen + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                chk("tap_state", 32'(tap_state), 32'(e.st));
                chk("tdo", 32'(tdo), 32'(e.tdo));
                chk("tdo_oe", 32'(tdo_oe), 32'(e.oe));
                chk("ir", 32'(ir), 32'(e.ir));
                chk("user_update_data", user_update_data, e.upd);
                chk("user_update_pulses", 32'(n_upd_seen), 32'(e.nupd));
                chk("user_capture_pulses", 32'(n_cap_seen), 32'(e.ncap));
            end
        end
    end

    function automatic int dr_kind();
        if (ID_EN && m_ir == 4'h1) return 1;
        if (m_ir == 4'h8) return 2;
        return 0;
    endfunction

    task automatic push_exp();
        exp_t e;
        e.st = 4'(m_st); e.tdo = m_tdo; e.oe = (m_st == 4 || m_st == 11);
        e.ir = m_ir; e.upd = m_upd; e.nupd = m_nupd; e.ncap = m_ncap;
        q.push_back(e);
    endtask

    task automatic model_reset();
        m_st = 0; m_tdo = 1'b0; m_ir = DEF_IR; m_irsr = '0;
        m_id = '0; m_usr = '0; m_byp = 1'b0; m_upd = '0;
    endtask

    task automatic model_cycle(input bit tm, input bit ti);
        int k = dr_kind();
        case (m_st)
            10: m_irsr = 4'b0001;
            11: m_irsr = {ti, m_irsr[3:1]};
            3: begin
                if (k == 1)      m_id = 32'h149511C3;
                else if (k == 2) begin m_usr = user_capture_data; m_ncap++; end
                else             m_byp = 1'b0;
            end
            4: begin
                if (k == 1)      m_id  = {ti, m_id[31:1]};
                else if (k == 2) m_usr = {ti, m_usr[31:1]};
                else             m_byp = ti;
            end
            default: ;
        endcase
        m_st = tm ? nxt1[m_st] : nxt0[m_st];
        if (m_st == 0) m_ir = DEF_IR;
        k = dr_kind();
        case (m_st)
            11: m_tdo = m_irsr[0];
            4:  m_tdo = (k == 1) ? m_id[0] : (k == 2) ? m_usr[0] : m_byp;
            15: m_ir = m_irsr;
            8:  if (k == 2) begin m_upd = m_usr; m_nupd++; end
            default: ;
        endcase
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tck_cycle(input bit tm, input bit ti);
        tms = tm; tdi = ti;
        wclk(2);
        tck = 1'b1;
        wclk(6);
        tck = 1'b0;
        wclk(6);
        model_cycle(tm, ti);
        push_exp();
    endtask

    task automatic do_reset();
        tck = 1'b0; rst = 1'b1;
        wclk(3);
        rst = 1'b0;
        wclk(1);
        model_reset();
        push_exp();
    endtask

    task automatic goto_rti();
        repeat (5) tck_cycle(1'b1, 1'($urandom));
        tck_cycle(1'b0, 1'b0);
    endtask

    task automatic scan_ir(input logic [3:0] v);
        tck_cycle(1, 0); tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
        for (int i = 0; i < 4; i++) tck_cycle(i == 3, v[i]);
        tck_cycle(1, 0); tck_cycle(0, 0);
    endtask

    task automatic scan_dr(input logic [31:0] v, input int n);
        tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
        for (int i = 0; i < n; i++) tck_cycle(i == n - 1, (i < 32) ? v[i] : 1'($urandom));
        tck_cycle(1, 0); tck_cycle(0, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; tck = 1'b0; tms = 1'b0; tdi = 1'b0; user_capture_data = '0;
        model_reset();
        do_reset();

        goto_rti();
        scan_dr(32'h0, 32);

        user_capture_data = $urandom;
        scan_ir(4'h8);
        scan_dr(32'hDEADBEEF, 32);

        scan_ir(4'h5);
        scan_dr(32'b1101, 4);

        for (int r = 0; r < 6; r++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 2) == 0) ? 4'h8 : 4'($urandom);
            user_capture_data = $urandom;
            goto_rti();
            scan_ir(op);
            scan_dr($urandom, $urandom_range(1, 40));
            for (int i = 0; i < 30; i++) begin
                if ($urandom_range(0, 9) == 0) user_capture_data = $urandom;
                tck_cycle(($urandom_range(0, 2) == 0), 1'($urandom));
            end
        end

        goto_rti();
        user_capture_data = $urandom;
        scan_ir(4'h8);
        tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
        for (int i = 0; i < 10; i++) tck_cycle(0, 1'($urandom));
        do_reset();
        for (int i = 0; i < 3; i++) tck_cycle(1, 0);

        wclk(3);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jtag_tap_sync.md
JTAG_TAP_SYNC -- requirements
Module: jtag_tap_sync

Interface
REQ-001 Parameter IR_LEN, default 4: instruction register width, minimum 2.
REQ-002 Parameter USER_DR_LEN, default 32: user data register width, minimum 1.
REQ-003 Parameter IDCODE_VALUE, default 32'h149511C3: IDCODE register contents; bit 0 SHALL be 1.
REQ-004 Parameter USER_OP, default 4'h8: IR code selecting the user DR.
REQ-005 Parameter SYNC_STAGES, default 2: synchronizer depth on tck/tms/tdi.
REQ-006 clk  input  1  system clock; sole clock; all flops on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 tck  input  1  JTAG clock, asynchronous to clk, oversampled.
REQ-009 tms  input  1  JTAG mode select, asynchronous.
REQ-010 tdi  input  1  JTAG data in, asynchronous.
REQ-011 tdo  output  1  JTAG data out.
REQ-012 tdo_oe  output  1  high while the FSM is in Shift-DR or Shift-IR.
REQ-013 user_capture_data  input  USER_DR_LEN  parallel value loaded in Capture-DR when USER_OP is active.
REQ-014 user_update_data  output  USER_DR_LEN  user DR contents latched in Update-DR.
REQ-015 user_capture  output  1  one-clk pulse when user DR is captured.
REQ-016 user_update  output  1  one-clk pulse when user_update_data changes.
REQ-017 tap_state  output  4  current TAP state, encoding per REQ-020.
REQ-018 ir  output  IR_LEN  current latched instruction.

Function
REQ-019 tck, tms, tdi SHALL each pass through SYNC_STAGES flops; tck rise/fall events are detected by comparing the last synchronized tck sample against one extra registered copy; each event is a single-clk strobe SYNC_STAGES+1 clk cycles after the pin edge.
REQ-020 FSM states/encoding: TLR=0, RTI=1, SEL_DR=2, CAP_DR=3, SH_DR=4, EX1_DR=5, PAU_DR=6, EX2_DR=7, UPD_DR=8, SEL_IR=9, CAP_IR=10, SH_IR=11, EX1_IR=12, PAU_IR=13, EX2_IR=14, UPD_IR=15.
REQ-021 FSM SHALL advance only on a tck-rise strobe, using synchronized tms, per IEEE 1149.1: tms=1 -> TLR->TLR, RTI/UPD_*->SEL_DR, SEL_DR->SEL_IR, SEL_IR->TLR, CAP/SH->EX1, PAU->EX2, EX1/EX2->UPD; tms=0 -> TLR/RTI/UPD_*->RTI, SEL->CAP, CAP/SH->SH, EX1/PAU->PAU, EX2->SH.
REQ-022 Five consecutive tck rises with tms=1 SHALL reach TLR from any state.
REQ-023 On a tck rise while in CAP_IR: IR shift register loads {zeros, 2'b01}.
REQ-024 On a tck rise while in CAP_DR: selected DR loads IDCODE_VALUE (IDCODE), user_capture_data with user_capture pulse (USER_OP), or 0 (BYPASS).
REQ-025 On a tck rise while in SH_IR/SH_DR: selected shift register shifts right, tdi into MSB; BYPASS is 1 bit.
REQ-026 On a tck fall: tdo <= LSB of selected shift register while in SH_IR/SH_DR; tdo holds its value otherwise.
REQ-027 On a tck fall while in UPD_IR: ir <= IR shift register. On a tck fall while in UPD_DR with USER_OP: user_update_data <= user shift register, user_update pulses that clk.
REQ-028 Any ir value other than IDCODE (IR_LEN'h1, when enabled) or USER_OP SHALL select BYPASS; all-ones is BYPASS.
REQ-029 Entering TLR SHALL reload ir with the default instruction (REQ-034) on the same strobe.
REQ-030 tck high/low time SHALL be >= SYNC_STAGES+2 clk periods; shorter pulses are unsupported and undetected edges are not flagged.

Reset
REQ-031 rst SHALL set: FSM=TLR, ir=default instruction, all shift registers 0, tdo=0, tdo_oe=0, user_update_data=0, pulses 0, synchronizer flops 0.
REQ-032 rst asserted mid-shift SHALL abort the scan; no update occurs and user_update_data keeps its reset value 0.

Configuration
REQ-033 Macro JTAG_TAP_IDCODE_EN SHALL gate the IDCODE instruction and register.
REQ-034 Defined: IR code 1 selects IDCODE, default instruction is IDCODE. Undefined: no IDCODE register, code 1 is BYPASS, default instruction is all-ones (BYPASS).

Verification
REQ-035 rst, then 5 tck rises tms=1, 1 rise tms=0 -> tap_state=1, ir=4'h1 (IDCODE_EN defined) or 4'hF (undefined).
REQ-036 IDCODE_EN defined, go SH_DR, shift 32 bits tdi=0 -> tdo sequence LSB-first equals 32'h149511C3.
REQ-037 Load IR=4'h8, shift DR with tdi 32'hDEADBEEF, pass UPD_DR -> user_update_data=32'hDEADBEEF, one user_update pulse; IR shift-out during load = 4'b0001 LSB-first.
REQ-038 Load IR=4'h5, shift DR with tdi pattern 1,0,1,1 -> tdo returns 0 then 1,0,1 (one-bit bypass delay).
REQ-039 Assert rst during SH_DR after 10 bits of a USER_OP scan -> tap_state=0, tdo_oe=0, no user_update pulse, user_update_data=0.
